// File: rtl/uart_pkg.sv
// Shared UART receive definitions.
//   rx_state_e : receiver FSM states
//   PAR_EVEN / PAR_ODD : par_typ encodings
//   PRESC_8 / PRESC_16 / PRESC_32 : legal oversampling ratios
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-point majority sampler for the UART receiver.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rx_i                : (synchronised) serial line
//   run_i               : FSM is inside a frame (counter free-runs)
//   start_i             : start edge detected this cycle (counter loads 1)
//   presc_i             : latched oversampling ratio
//   maj_c_o             : majority of samples at edges h-1, h, h+1 (h = presc/2)
//   sample_valid_c_o    : strobe at edge h+1, maj_c_o is meaningful
//   bit_end_c_o         : strobe at edge presc-1, last cycle of the bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    input  logic                  run_i,
    input  logic                  start_i,
    input  logic [PRESCALE_W-1:0] presc_i,
    output logic                  maj_c_o,
    output logic                  sample_valid_c_o,
    output logic                  bit_end_c_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;
    logic                  s0_q;
    logic                  s1_q;

    // Sample-point and wrap thresholds derived from the latched ratio.
    always_comb begin
        half = presc_i >> 1;
        last = presc_i - PRESCALE_W'(1);
    end

    // Edge counter plus the two early samples of the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
        end else begin
            // The detect cycle itself is edge 0, so the count resumes at 1.
            if (start_i) begin
                edge_cnt_q <= PRESCALE_W'(1);
            end else if (!run_i) begin
                edge_cnt_q <= '0;
            end else if (edge_cnt_q == last) begin
                edge_cnt_q <= '0;
            end else begin
                edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
            end

            if (run_i && (edge_cnt_q == (half - PRESCALE_W'(1)))) begin
                s0_q <= rx_i;
            end
            if (run_i && (edge_cnt_q == half)) begin
                s1_q <= rx_i;
            end
        end
    end

    // Third sample is taken live at edge h+1; the FSM registers the vote.
    always_comb begin
        maj_c_o          = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
        sample_valid_c_o = run_i && (edge_cnt_q == (half + PRESCALE_W'(1)));
        bit_end_c_o      = run_i && (edge_cnt_q == last);
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start bit, DATA_W data bits LSB first, optional
// parity bit, one stop bit. Clocked at prescale x baud.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   RX_IN       : serial line, idles high
//   prescale    : oversampling ratio (8/16/32), latched at frame start
//   par_en      : frame carries a parity bit, latched at frame start
//   par_typ     : 0 even / 1 odd parity, latched at frame start
//   P_DATA      : last good data word (held across frames and errored frames)
//   data_valid  : one-cycle pulse when P_DATA updates
//   par_err     : one-cycle pulse on parity mismatch
//   stp_err     : one-cycle pulse when the stop bit samples 0
//   busy        : FSM outside IDLE
// Optional: define UART_RX_FRAME_SYNC_EN to pass RX_IN through a 2-flop
// synchroniser (reset to 1); all response times then shift by +2 clk.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e             state_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0]     shift_q;
    logic                  mismatch_q;
    logic                  stop_bad_q;
    logic [DATA_W-1:0]     p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  busy_q;

    logic rx_s;
    logic run;
    logic start_det;
    logic maj;
    logic sample_valid;
    logic bit_end;

    // Line conditioning.
`ifdef UART_RX_FRAME_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    assign run       = (state_q != IDLE);
    assign start_det = (state_q == IDLE) && !rx_s;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk              (clk),
        .rst              (rst),
        .rx_i             (rx_s),
        .run_i            (run),
        .start_i          (start_det),
        .presc_i          (presc_q),
        .maj_c_o          (maj),
        .sample_valid_c_o (sample_valid),
        .bit_end_c_o      (bit_end)
    );

    // Frame FSM with registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            mismatch_q   <= 1'b0;
            stop_bad_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        presc_q    <= prescale;
                        par_en_q   <= par_en;
                        par_typ_q  <= par_typ;
                        bit_cnt_q  <= '0;
                        mismatch_q <= 1'b0;
                        stop_bad_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                START: begin
                    // A high majority at the bit centre means the low was a glitch.
                    if (sample_valid && maj) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= DATA;
                    end
                end

                DATA: begin
                    if (sample_valid) begin
                        shift_q[bit_cnt_q] <= maj;
                    end
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (sample_valid) begin
                        mismatch_q <= (maj != ((^shift_q) ^ par_typ_q));
                    end
                    if (bit_end) begin
                        state_q <= STOP;
                    end
                end

                STOP: begin
                    if (sample_valid) begin
                        stop_bad_q <= !maj;
                    end
                    if (bit_end) begin
                        stp_err_q <= stop_bad_q;
                        par_err_q <= par_en_q && mismatch_q;
                        if (!stop_bad_q && !(par_en_q && mismatch_q)) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_q;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule
